// File: rtl/mod_99_preempt_sched_pkg.sv
// Shared encodings for the MAC Merge transmit scheduler: 99.5 transmit FSM
// state codes, scheduler state codes and frame-length constants.
package mod_99_preempt_sched_pkg;

  localparam int MIN_FRAME_OCT = 64;
  localparam int CRC_LEN_OCT   = 4;
  localparam int CNT_W_DEF     = 11;

  typedef enum logic [3:0] {
    TX_SEND_SMD_S  = 4'h7,
    TX_PREEMPTABLE = 4'h9,
    TX_MCRC        = 4'hA,
    TX_SEND_SMD_C  = 4'hD
  } tx_state_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXPRESS = 3'd1,
    S_PTX     = 3'd2,
    S_PREEMPT = 3'd3,
    S_SUSPEND = 3'd4
  } sched_state_e;

endpackage

// File: rtl/mod_99_preempt_sched_frag_counter.sv
// Tracks octets sent in the current preemptable fragment and decides whether
// the minimum-fragment rules currently allow a preemption.
module mod_99_frag_counter
  import mod_99_preempt_sched_pkg::*;
#(
  parameter int MIN_FRAME = MIN_FRAME_OCT,
  parameter int CRC_LEN   = CRC_LEN_OCT,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_begin,
  input  logic             p_active,
  input  logic [1:0]       add_frag_size,
  input  logic [CNT_W-1:0] p_remain,
  input  logic             tx_octet,
  input  logic [3:0]       tx_state,
  output logic [CNT_W-1:0] frag_cnt,
  output logic [CNT_W-1:0] min_frag,
  output logic             can_preempt
);

  function automatic logic [CNT_W-1:0] calc_min_frag(input logic [1:0] afs);
    int len;
    len = MIN_FRAME * (int'(afs) + 1) - CRC_LEN;
    return CNT_W'(len);
  endfunction

  logic smd_seen;
  logic count_en;

  assign smd_seen = (tx_state == TX_SEND_SMD_S) || (tx_state == TX_SEND_SMD_C);
  assign count_en = tx_octet && (tx_state == TX_PREEMPTABLE);

  always_ff @(posedge clk) begin
    if (reset_begin) begin
      frag_cnt <= '0;
    end else if (smd_seen) begin
      frag_cnt <= '0;
    end else if (count_en && (frag_cnt != {CNT_W{1'b1}})) begin
      frag_cnt <= frag_cnt + 1'b1;
    end
  end

  assign min_frag = calc_min_frag(add_frag_size);
  // The remainder must itself form a legal final fragment once preempted.
  assign can_preempt = p_active && (frag_cnt >= min_frag) &&
                       (p_remain >= CNT_W'(MIN_FRAME));

endmodule

// File: rtl/mod_99_preempt_sched.sv
// MAC Merge transmit scheduler: arbitrates express vs preemptable requests and
// drives eTx/pTX/hold/preempt for the 99.5 transmit processing state machine.
module mod_99_preempt_sched
  import mod_99_preempt_sched_pkg::*;
#(
  parameter int MIN_FRAME = MIN_FRAME_OCT,
  parameter int CRC_LEN   = CRC_LEN_OCT,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_begin,
  input  logic             p_active,
  input  logic [1:0]       add_frag_size,
  input  logic             hold_req,
  input  logic             e_req,
  input  logic             e_done,
  input  logic             p_req,
  input  logic             p_cplt,
  input  logic [CNT_W-1:0] p_remain,
  input  logic             tx_octet,
  input  logic [3:0]       tx_state,
  output logic             eTx,
  output logic             pTX,
  output logic             hold,
  output logic             preempt,
  output logic [CNT_W-1:0] frag_cnt,
  output logic [2:0]       sched_state
);

  sched_state_e state, state_nxt;
  logic         p_susp, p_susp_nxt;
  logic         hold_now;
  logic         can_preempt;
  logic [CNT_W-1:0] min_frag;

  mod_99_frag_counter #(
    .MIN_FRAME (MIN_FRAME),
    .CRC_LEN   (CRC_LEN),
    .CNT_W     (CNT_W)
  ) u_frag (
    .clk           (clk),
    .reset_begin   (reset_begin),
    .p_active      (p_active),
    .add_frag_size (add_frag_size),
    .p_remain      (p_remain),
    .tx_octet      (tx_octet),
    .tx_state      (tx_state),
    .frag_cnt      (frag_cnt),
    .min_frag      (min_frag),
    .can_preempt   (can_preempt)
  );

  assign hold_now = hold_req && p_active;

  always_comb begin
    state_nxt  = state;
    p_susp_nxt = p_susp;
    unique case (state)
      S_IDLE: begin
        if (e_req) begin
          state_nxt = S_EXPRESS;
        end else if (p_req && !hold_now) begin
          state_nxt = S_PTX;
        end
      end
      S_EXPRESS: begin
        if (e_done) begin
          state_nxt = p_susp ? S_SUSPEND : S_IDLE;
        end
      end
      S_PTX: begin
        if (p_cplt) begin
          state_nxt  = S_IDLE;
          p_susp_nxt = 1'b0;
        end else if (e_req && can_preempt) begin
          state_nxt = S_PREEMPT;
        end
      end
      S_PREEMPT: begin
        // A natural frame end beats the mCRC handoff in the same cycle.
        if (p_cplt) begin
          state_nxt  = S_IDLE;
          p_susp_nxt = 1'b0;
        end else if (tx_state == TX_MCRC) begin
          state_nxt  = S_EXPRESS;
          p_susp_nxt = 1'b1;
        end
      end
      S_SUSPEND: begin
        if (p_cplt) begin
          state_nxt  = S_IDLE;
          p_susp_nxt = 1'b0;
        end else if (e_req) begin
          state_nxt = S_EXPRESS;
        end else if (!hold_now) begin
          state_nxt  = S_PTX;
          p_susp_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        p_susp_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state itself, keeping eTx and preempt mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset_begin) begin
      state   <= S_IDLE;
      p_susp  <= 1'b0;
      eTx     <= 1'b0;
      pTX     <= 1'b0;
      hold    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state   <= state_nxt;
      p_susp  <= p_susp_nxt;
      eTx     <= (state_nxt == S_EXPRESS);
      pTX     <= (state_nxt == S_PTX) || (state_nxt == S_PREEMPT) ||
                 (state_nxt == S_SUSPEND) ||
                 ((state_nxt == S_EXPRESS) && p_susp_nxt);
      hold    <= hold_now;
      preempt <= (state_nxt == S_PREEMPT);
    end
  end

  assign sched_state = state;

endmodule
